pe_chain_ctrl: RTL and testbench
================================

PE_CHAIN_CTRL -- requirements
Module: pe_chain_ctrl

Interface
REQ-001 SHALL have parameter NUM_PE, default 9, the number of PEs in the shift chain (3x3 kernel).
REQ-002 SHALL have parameter DATA_W, default 8, the signed sample width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a load/compute job.
REQ-006 SHALL have port cfg_len, input, $clog2(NUM_PE+1), the number of samples in the job, sampled on an accepted start.
REQ-007 SHALL have port src_valid, input, 1, source sample valid.
REQ-008 SHALL have port src_data, input, DATA_W, signed source sample.
REQ-009 SHALL have port src_ready, output, 1, controller accepts a sample; a transfer is src_valid & src_ready.
REQ-010 SHALL have port pe_valid, output, 1, shift strobe driven to every PE valid input.
REQ-011 SHALL have port pe_data, output, DATA_W, sample driven into the chain head.
REQ-012 SHALL have port pe_enable, output, NUM_PE, per-PE enable to the multiplier bar; bit 0 is the head PE.
REQ-013 SHALL have port mac_ready, input, 1, the multiplier bar can consume the enabled products.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at job completion.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, PAD, COMPUTE, DONE.
REQ-017 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-018 SHALL treat start with cfg_len==0 as a null job: IDLE->DONE with no shifts.
REQ-019 SHALL saturate cfg_len>NUM_PE to NUM_PE.
REQ-020 SHALL move IDLE->LOAD on an accepted start with nonzero length, and clear the sample counter.
REQ-021 In LOAD, SHALL drive src_ready=1; on each transfer SHALL assert pe_valid for that same cycle, drive pe_data=src_data combinationally, and increment the counter.
REQ-022 In LOAD with src_valid=0, SHALL hold pe_valid=0 so the chain holds its contents.
REQ-023 On the transfer that makes count==len, SHALL leave LOAD; the next state is PAD if the pad feature is enabled and len<NUM_PE, otherwise COMPUTE.
REQ-024 In PAD, SHALL drive src_ready=0, pe_valid=1 and pe_data=0 each cycle for exactly NUM_PE-len cycles, then go to COMPUTE.
REQ-025 In COMPUTE, SHALL drive pe_enable with the registered job mask while mac_ready=1, and zero while mac_ready=0.
REQ-026 The job mask SHALL be: without padding, the low len bits set; with padding, the high len bits set, because the data sits at the chain tail.
REQ-027 COMPUTE SHALL last exactly one cycle with mac_ready=1, then go to DONE; while mac_ready=0 it SHALL wait indefinitely.
REQ-028 DONE SHALL pulse done=1 for one cycle and return to IDLE.
REQ-029 pe_valid, src_ready and pe_enable SHALL be 0 in IDLE and DONE, so the chain is never shifted outside LOAD and PAD.
REQ-030 Latency from start to done, with src_valid and mac_ready held high, SHALL be len + pad + 2 cycles.

Reset
REQ-031 rst=1 SHALL force IDLE, clear the counter, mask and stored length, and drive src_ready=0, pe_valid=0, pe_data=0, pe_enable=0, busy=0 and done=0 on the next edge.
REQ-032 Reset asserted mid-job SHALL abort the job with no done pulse; PE contents are not the controller's responsibility.

Configuration
REQ-033 Macro PE_CHAIN_CTRL_ZERO_PAD_EN defined SHALL compile in the PAD state and tail-aligned masking, and REQ-024 and REQ-026 apply.
REQ-034 Without the macro, PAD SHALL be absent, LOAD SHALL go directly to COMPUTE, and the mask SHALL be head-aligned.

Structure
REQ-035 A shared package pe_pkg SHALL hold the FSM state typedef and the default NUM_PE/DATA_W constants.
REQ-036 One sub-module SHALL be used: pe_len_mask, a combinational len-to-thermometer mask generator with a tail-align parameter.

Verification
REQ-037 len=9, src_valid held high, mac_ready=1 -> 9 pe_valid pulses carrying the sample values, pe_enable=9'h1FF for 1 cycle, done 11 cycles after start.
REQ-038 len=4, pad enabled -> 4 data shifts then 5 zero shifts, pe_enable=9'h1E0; pad disabled -> pe_enable=9'h00F, no zero shifts.
REQ-039 len=3, src_valid toggling 1,0,1,0,1 -> exactly 3 pe_valid pulses aligned with the transfers, and pe_valid=0 on idle cycles.
REQ-040 mac_ready=0 for 5 cycles in COMPUTE -> pe_enable=0 and busy=1 throughout, then mask for 1 cycle once mac_ready=1, then done.
REQ-041 start during LOAD ignored; rst pulsed mid-LOAD -> all outputs 0 next cycle, no done, and a new start is accepted afterward.
REQ-042 cfg_len=0 -> done 1 cycle after start, no pe_valid; cfg_len=12 -> treated as 9.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the PE shift-chain controller.
// Holds the default chain geometry (3x3 kernel, 8-bit samples) and the
// controller FSM state type with its state constants.
package pe_pkg;

  localparam int unsigned NUM_PE_DEF = 9;
  localparam int unsigned DATA_W_DEF = 8;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StLoad    = 3'd1;
  localparam state_t StPad     = 3'd2;
  localparam state_t StCompute = 3'd3;
  localparam state_t StDone    = 3'd4;

endpackage

// File: rtl/pe_len_mask.sv
// pe_len_mask: combinational length-to-thermometer mask generator.
// Ports:
//   len  - number of active PEs (0..NUM_PE)
//   mask - NUM_PE-bit mask; bit 0 is the chain head
// TAIL_ALIGN=0 sets the low len bits, TAIL_ALIGN=1 sets the high len bits.
module pe_len_mask #(
  parameter int unsigned NUM_PE     = 9,
  parameter int unsigned LEN_W      = 4,
  parameter bit          TAIL_ALIGN = 1'b0
) (
  input  logic [LEN_W-1:0]  len,
  output logic [NUM_PE-1:0] mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(NUM_PE); i++) begin
      if (TAIL_ALIGN) begin
        mask[i] = (i >= int'(NUM_PE) - int'(len));
      end else begin
        mask[i] = (i < int'(len));
      end
    end
  end

endmodule

// File: rtl/pe_chain_ctrl.sv
// pe_chain_ctrl: load/compute sequencer for a shift chain of NUM_PE PEs.
// A job streams cfg_len source samples into the chain head, optionally
// flushes the chain with zeros, then enables the multiplier bar for one
// accepted cycle and pulses done.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   start, cfg_len        - job request (IDLE only) and sample count
//   src_valid/ready/data  - source sample handshake
//   pe_valid, pe_data     - shift strobe and head sample to the chain
//   pe_enable, mac_ready  - per-PE product enable and bar back-pressure
//   busy, done            - not-idle flag, one-cycle completion pulse
// Build option: PE_CHAIN_CTRL_ZERO_PAD_EN adds the zero-pad state and
// tail-aligned product masking.
module pe_chain_ctrl
  import pe_pkg::*;
#(
  parameter int unsigned NUM_PE = NUM_PE_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(NUM_PE+1)-1:0]  cfg_len,
  input  logic                         src_valid,
  input  logic signed [DATA_W-1:0]     src_data,
  output logic                         src_ready,
  output logic                         pe_valid,
  output logic signed [DATA_W-1:0]     pe_data,
  output logic [NUM_PE-1:0]            pe_enable,
  input  logic                         mac_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned LenW = $clog2(NUM_PE + 1);

`ifdef PE_CHAIN_CTRL_ZERO_PAD_EN
  localparam bit PadEn = 1'b1;
`else
  localparam bit PadEn = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [LenW-1:0]   cnt_q, cnt_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [NUM_PE-1:0] mask_q, mask_d;
  logic [LenW-1:0]   sat_len;
  logic [NUM_PE-1:0] start_mask;
  logic [LenW-1:0]   cnt_inc;

  assign sat_len = (cfg_len > LenW'(NUM_PE)) ? LenW'(NUM_PE) : cfg_len;
  assign cnt_inc = cnt_q + LenW'(1);

  // With padding the loaded samples end up at the chain tail.
  pe_len_mask #(
    .NUM_PE     (NUM_PE),
    .LEN_W      (LenW),
    .TAIL_ALIGN (PadEn)
  ) u_len_mask (
    .len  (sat_len),
    .mask (start_mask)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    mask_d    = mask_q;
    src_ready = 1'b0;
    pe_valid  = 1'b0;
    pe_data   = '0;
    pe_enable = '0;
    done      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = sat_len;
          mask_d  = start_mask;
          cnt_d   = '0;
          state_d = (sat_len == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        src_ready = 1'b1;
        pe_valid  = src_valid;
        pe_data   = src_data;
        if (src_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
`ifdef PE_CHAIN_CTRL_ZERO_PAD_EN
            state_d = (len_q < LenW'(NUM_PE)) ? StPad : StCompute;
`else
            state_d = StCompute;
`endif
          end
        end
      end
`ifdef PE_CHAIN_CTRL_ZERO_PAD_EN
      StPad: begin
        // The counter keeps running until the whole chain has been shifted.
        pe_valid = 1'b1;
        cnt_d    = cnt_inc;
        if (cnt_inc == LenW'(NUM_PE)) begin
          state_d = StCompute;
        end
      end
`endif
      StCompute: begin
        if (mac_ready) begin
          pe_enable = mask_q;
          state_d   = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mask_q  <= mask_d;
    end
  end

endmodule

// File: tb/tb_pe_chain_ctrl.sv
module tb_pe_chain_ctrl;

  localparam int NPE  = 9;
  localparam int DW   = 8;
  localparam int LW   = 4;
  localparam int MAXC = 256;

`ifdef PE_CHAIN_CTRL_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst, start, src_valid, src_ready, pe_valid, mac_ready, busy, done;
  logic [LW-1:0]        cfg_len;
  logic signed [DW-1:0] src_data, pe_data;
  logic [NPE-1:0]       pe_enable;

  int total = 0;
  int bad   = 0;

  bit        sv[MAXC];
  logic [7:0] sd[MAXC];
  bit        mr[MAXC];

  always #5 clk = ~clk;

  pe_chain_ctrl #(.NUM_PE(NPE), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .pe_valid  (pe_valid),
    .pe_data   (pe_data),
    .pe_enable (pe_enable),
    .mac_ready (mac_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " src_ready"}, 32'(src_ready), 0);
    chk({tag, " pe_valid"}, 32'(pe_valid), 0);
    chk({tag, " pe_enable"}, 32'(pe_enable), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " pe_data"}, 32'(pe_data), 0);
  endtask

  // Reference: a job of n = min(cfg, 9) samples takes the first n cycles with
  // src_valid high, then PAD zero shifts, then the first cycle with mac_ready
  // high releases the mask, and done follows one cycle later.
  // src_mode: 0 held, 1 pattern, 2 random. mr_mode: 0 held, 1 low mr_low
  // cycles into compute, 2 random.
  task automatic run_job(input int cfg, input int src_mode, input logic [31:0] pat,
                         input int mr_mode, input int mr_low,
                         output int obs_done, output logic [NPE-1:0] obs_mask);
    int sl, pad, l_end, c0, cc, dn, got, m;
    bit in_load, in_pad, exp_valid;
    logic [NPE-1:0] mask;
    sl  = (cfg > NPE) ? NPE : cfg;
    pad = (PAD && sl > 0 && sl < NPE) ? NPE - sl : 0;
    m   = (1 << sl) - 1;
    if (PAD) m = m << (NPE - sl);
    mask = m[NPE-1:0];
    for (int k = 1; k < MAXC; k++) begin
      case (src_mode)
        0:       sv[k] = 1'b1;
        1:       sv[k] = pat[(k - 1) % 32];
        default: sv[k] = ($urandom_range(0, 1) == 1) || (k > 100);
      endcase
      sd[k] = 8'($urandom);
    end
    l_end = 0;
    got   = 0;
    for (int k = 1; k < MAXC && got < sl; k++) begin
      if (sv[k]) begin
        got++;
        if (got == sl) l_end = k;
      end
    end
    c0 = l_end + pad + 1;
    for (int k = 1; k < MAXC; k++) begin
      case (mr_mode)
        0:       mr[k] = 1'b1;
        1:       mr[k] = (k >= c0 + mr_low);
        default: mr[k] = ($urandom_range(0, 2) != 0) || (k > c0 + 30);
      endcase
    end
    if (sl == 0) begin
      cc = -1;
      dn = 1;
    end else begin
      cc = c0;
      while (!mr[cc]) cc++;
      dn = cc + 1;
    end

    @(posedge clk); #1;
    start     = 1'b1;
    cfg_len   = LW'(cfg);
    src_valid = 1'b0;
    mac_ready = 1'b0;
    @(negedge clk);
    chk_quiet("job idle");
    obs_done = -1;
    obs_mask = '0;
    for (int k = 1; k <= dn + 1; k++) begin
      @(posedge clk); #1;
      start     = (k <= dn) ? ($urandom_range(0, 3) == 0) : 1'b0;
      cfg_len   = LW'($urandom);
      src_valid = sv[k];
      src_data  = sd[k];
      mac_ready = mr[k];
      @(negedge clk);
      in_load   = (sl > 0) && (k <= l_end);
      in_pad    = (sl > 0) && (k > l_end) && (k <= l_end + pad);
      exp_valid = (in_load && sv[k]) || in_pad;
      chk($sformatf("len%0d c%0d src_ready", sl, k), 32'(src_ready), 32'(in_load));
      chk($sformatf("len%0d c%0d pe_valid", sl, k), 32'(pe_valid), 32'(exp_valid));
      if (exp_valid)
        chk($sformatf("len%0d c%0d pe_data", sl, k), 32'(pe_data & 8'hFF),
            in_pad ? 32'd0 : 32'(sd[k]));
      chk($sformatf("len%0d c%0d pe_enable", sl, k), 32'(pe_enable),
          (k == cc) ? 32'(mask) : 32'd0);
      chk($sformatf("len%0d c%0d busy", sl, k), 32'(busy), 32'(k <= dn));
      chk($sformatf("len%0d c%0d done", sl, k), 32'(done), 32'(k == dn));
      if (done && obs_done < 0) obs_done = k;
      if (pe_enable != '0) obs_mask = pe_enable;
    end
    start = 1'b0;
  endtask

  typedef struct {
    int             cfg;
    int             src_mode;
    logic [31:0]    pat;
    int             mr_mode;
    int             mr_low;
    int             exp_lat;
    logic [NPE-1:0] exp_mask;
  } vec_t;

  vec_t           tbl[6];
  int             od;
  logic [NPE-1:0] om;

  initial begin
    tbl[0] = '{9, 0, 32'h0, 0, 0, 11, 9'h1FF};
    tbl[1] = '{4, 0, 32'h0, 0, 0, PAD ? 11 : 6, PAD ? 9'h1E0 : 9'h00F};
    tbl[2] = '{3, 1, 32'h15, 0, 0, PAD ? 13 : 7, PAD ? 9'h1C0 : 9'h007};
    tbl[3] = '{9, 0, 32'h0, 1, 5, 16, 9'h1FF};
    tbl[4] = '{0, 0, 32'h0, 0, 0, 1, 9'h000};
    tbl[5] = '{12, 0, 32'h0, 0, 0, 11, 9'h1FF};

    rst       = 1'b1;
    start     = 1'b0;
    cfg_len   = '0;
    src_valid = 1'b1;
    src_data  = 8'sh5A;
    mac_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_job(tbl[i].cfg, tbl[i].src_mode, tbl[i].pat, tbl[i].mr_mode, tbl[i].mr_low, od, om);
      chk($sformatf("vec%0d latency", i), 32'(od), 32'(tbl[i].exp_lat));
      chk($sformatf("vec%0d mask", i), 32'(om), 32'(tbl[i].exp_mask));
    end

    // Reset in the middle of a load aborts the job without a done pulse.
    @(posedge clk); #1;
    start     = 1'b1;
    cfg_len   = 4'd6;
    src_valid = 1'b1;
    src_data  = 8'sh33;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midload pe_valid", 32'(pe_valid), 1);
    chk("midload pe_data", 32'(pe_data & 8'hFF), 32'h33);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("after abort");
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("abort no done c%0d", k), 32'(done | busy), 0);
    end
    run_job(5, 0, 32'h0, 0, 0, od, om);
    chk("restart latency", 32'(od), PAD ? 32'd11 : 32'd7);

    for (int j = 0; j < 20; j++) begin
      run_job(int'($urandom_range(0, 15)), 2, 32'h0, 2, 0, od, om);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
